// File: rtl/multicycle_chunk_adder.sv
// multicycle_chunk_adder: a + b + cin over WIDTH bits, CHUNK bits per clock.
// Define ADDER_OVF_EN to build the signed-overflow output ovf.
module multicycle_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("multicycle_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [CHUNK-1:0] ach;
   logic [CHUNK-1:0] bch;
   logic [CHUNK:0]   csum;
   logic             last;
   logic             accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = (state == IDLE) && in_valid;
   assign last      = (idx == IW'(NCHUNK - 1));

   // Constant-index mux keeps the chunk select free of variable part-selects.
   always_comb begin
      ach = '0;
      bch = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IW'(i)) begin
            ach = opa[i*CHUNK +: CHUNK];
            bch = opb[i*CHUNK +: CHUNK];
         end
      end
      csum = {1'b0, ach} + {1'b0, bch} + {{CHUNK{1'b0}}, carry};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nx = BUSY;
         BUSY:    if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         s     <= '0;
         cout  <= 1'b0;
      end else begin
         if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            idx   <= '0;
         end
         if (state == BUSY) begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (idx == IW'(i)) begin
                  s[i*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
               end
            end
            carry <= csum[CHUNK];
            idx   <= last ? '0 : idx + IW'(1);
            if (last) begin
               cout <= csum[CHUNK];
            end
         end
      end
   end

`ifdef ADDER_OVF_EN
   // The final chunk's top sum bit is the result sign bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (state == BUSY && last) begin
         ovf <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                (csum[CHUNK-1] != opa[WIDTH-1]);
      end
   end
`else
   // ovf is not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Directed and random checks of multicycle_chunk_adder at 8/4 and 16/4.
module tb_multicycle_chunk_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, cin8 = 1'b0, co8;
   logic [7:0]  a8 = '0, b8 = '0, s8;
   logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, cin16 = 1'b0, co16;
   logic [15:0] a16 = '0, b16 = '0, s16;
   logic        ovf8, ovf16;
   bit          sel = 1'b0;
   int          nchk = 0;
   int          nfail = 0;

   always #5 clk = ~clk;

   multicycle_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
      .s(s8), .cout(co8)
`ifdef ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   multicycle_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
      .s(s16), .cout(co16)
`ifdef ADDER_OVF_EN
      , .ovf(ovf16)
`endif
   );

`ifndef ADDER_OVF_EN
   assign ovf8  = 1'b0;
   assign ovf16 = 1'b0;
`endif

   logic        r_ir, r_ov, r_co, r_ovf;
   logic [15:0] r_s;
   assign r_ir  = sel ? ir16 : ir8;
   assign r_ov  = sel ? ov16 : ov8;
   assign r_co  = sel ? co16 : co8;
   assign r_ovf = sel ? ovf16 : ovf8;
   assign r_s   = sel ? s16 : {8'h00, s8};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input bit w, input logic [15:0] x, input logic [15:0] y,
                     input logic c, input logic [15:0] es, input logic ec,
                     input logic eo, input int elat, input string tag);
      int n;
      sel = w;
      #0;
      if (w) begin
         a16 = x; b16 = y; cin16 = c; iv16 = 1'b1;
      end else begin
         a8 = x[7:0]; b8 = y[7:0]; cin8 = c; iv8 = 1'b1;
      end
      n = 0;
      while (r_ir !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, ".rdy"}, {31'd0, r_ir}, 32'd1);
      tick();
      iv8 = 1'b0;
      iv16 = 1'b0;
      n = 0;
      while (r_ov !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk({tag, ".lat"}, 32'(n), 32'(elat));
      chk({tag, ".s"}, {16'd0, r_s}, {16'd0, es});
      chk({tag, ".cout"}, {31'd0, r_co}, {31'd0, ec});
`ifdef ADDER_OVF_EN
      chk({tag, ".ovf"}, {31'd0, r_ovf}, {31'd0, eo});
`else
      if (eo === 1'bx) chk({tag, ".eo"}, 32'd0, 32'd1);
`endif
      if (w) or16 = 1'b1; else or8 = 1'b1;
      tick();
      or8 = 1'b0;
      or16 = 1'b0;
      chk({tag, ".ovlow"}, {31'd0, r_ov}, 32'd0);
      chk({tag, ".idle"}, {31'd0, r_ir}, 32'd1);
      chk({tag, ".shold"}, {16'd0, r_s}, {16'd0, es});
   endtask

   initial begin
      logic [15:0] x, y, es;
      logic [16:0] full;
      logic        c, eo;

      #1;
      chk("rst.in_ready", {31'd0, ir8}, 32'd1);
      chk("rst.out_valid", {31'd0, ov8}, 32'd0);
      chk("rst.s", {24'd0, s8}, 32'd0);
      chk("rst.cout", {31'd0, co8}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      op(0, 16'h00, 16'h00, 1'b0, 16'h00, 1'b0, 1'b0, 2, "zero");
      op(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, 2, "carry");
      op(0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1, 2, "ovf");
      op(0, 16'hFF, 16'h00, 1'b1, 16'h00, 1'b1, 1'b0, 2, "cin");
      op(0, 16'h80, 16'h80, 1'b0, 16'h00, 1'b1, 1'b1, 2, "negovf");

      sel = 1'b0;
      a8 = 8'h0A; b8 = 8'h05; cin8 = 1'b1; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      tick();
      tick();
      chk("hold.valid0", {31'd0, ov8}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         iv8 = 1'b1;
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         tick();
         chk("hold.valid", {31'd0, ov8}, 32'd1);
         chk("hold.s", {24'd0, s8}, 32'h10);
         chk("hold.in_ready", {31'd0, ir8}, 32'd0);
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      tick();
      or8 = 1'b0;
      chk("hold.release", {31'd0, ov8}, 32'd0);
      chk("hold.idle", {31'd0, ir8}, 32'd1);
      tick();
      chk("hold.noaccept", {31'd0, ir8}, 32'd1);

      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("abort.valid", {31'd0, ov8}, 32'd0);
      chk("abort.s", {24'd0, s8}, 32'd0);
      chk("abort.cout", {31'd0, co8}, 32'd0);
      chk("abort.in_ready", {31'd0, ir8}, 32'd1);
      tick();
      rst = 1'b0;
      tick();
      op(0, 16'h12, 16'h34, 1'b0, 16'h46, 1'b0, 1'b0, 2, "after_abort");

      op(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "w16carry");
      op(1, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 4, "w16ovf");

      for (int i = 0; i < 150; i++) begin
         bit w;
         w = (i % 2) == 1;
         x = w ? 16'($urandom) : {8'h00, 8'($urandom)};
         y = w ? 16'($urandom) : {8'h00, 8'($urandom)};
         c = 1'($urandom);
         full = {1'b0, x} + {1'b0, y} + {16'd0, c};
         if (w) begin
            es = full[15:0];
            eo = (x[15] == y[15]) && (es[15] != x[15]);
            op(1, x, y, c, es, full[16], eo, 4, "rand16");
         end else begin
            es = {8'h00, full[7:0]};
            eo = (x[7] == y[7]) && (es[7] != x[7]);
            op(0, x, y, c, es, full[8], eo, 2, "rand8");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
